reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL be parameterised: DATA_W, default 32, register width in bits.
REQ-002 The block SHALL be parameterised: ADDR_W, default 5, address width in bits; register count is 2**ADDR_W (32).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all writes.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 dest_addr  input  ADDR_W  write register index.
REQ-007 dest_data  input  DATA_W  write data.
REQ-008 write_enable  input  1  write strobe, active-high.
REQ-009 src1_addr  input  ADDR_W  read port 1 register index.
REQ-010 src2_addr  input  ADDR_W  read port 2 register index.
REQ-011 src1_data  output  DATA_W  read port 1 data.
REQ-012 src2_data  output  DATA_W  read port 2 data.

Function
REQ-013 Storage SHALL be 2**ADDR_W registers of DATA_W bits; register 0 SHALL read as all-zeros at all times.
REQ-014 When write_enable=1 and dest_addr!=0 at a rising clk edge, dest_data SHALL be stored in register dest_addr.
REQ-015 Writes with write_enable=0 or dest_addr=0 SHALL leave all storage unchanged.
REQ-016 Reads SHALL be combinational (zero-cycle latency): srcN_data = register[srcN_addr], updating within the same cycle as an address change.
REQ-017 Both read ports SHALL be independent; equal src1_addr and src2_addr SHALL return identical data.
REQ-018 A write SHALL be visible on any read port addressing that register from the cycle after the write edge.
REQ-019 Reads SHALL never return X once reset has been applied; all addresses are valid (no out-of-range case).

Reset
REQ-020 Asserting rst_n=0 SHALL immediately clear every register to 0, independent of clk.
REQ-021 While rst_n=0, writes SHALL be ignored and both outputs SHALL read 0.
REQ-022 Reset asserted on the same edge as a write SHALL take priority; the write SHALL be lost.
REQ-023 Writes SHALL resume on the first rising clk edge after rst_n deasserts.

Configuration
REQ-024 Macro REGFILE_BYPASS_EN SHALL select same-cycle write-to-read forwarding.
REQ-025 With REGFILE_BYPASS_EN defined: if write_enable=1, dest_addr!=0 and srcN_addr==dest_addr, srcN_data SHALL equal dest_data combinationally in that cycle.
REQ-026 Without REGFILE_BYPASS_EN: srcN_data SHALL show the stored (pre-write) value until the write edge; no forwarding logic SHALL be present.
REQ-027 Forwarding SHALL never apply to register 0, and SHALL be suppressed while rst_n=0.

Structure
REQ-028 Shared package reg_file_pkg SHALL hold DATA_W and ADDR_W defaults, NUM_REGS, and ZERO_REG index constant.
REQ-029 Read logic (address mux, zero-register force, optional bypass) SHALL be one sub-module, reg_file_read_port, instantiated once per read port.

Verification
REQ-030 Reset: rst_n=0 mid-run with all registers holding nonzero data -> src1_data=src2_data=0x00000000 for every address, immediately, without a clk edge.
REQ-031 Write/read: write 0xDEADBEEF to x5, then src1_addr=5, src2_addr=5 -> both ports 0xDEADBEEF next cycle.
REQ-032 Zero register: write 0x12345678 to x0 -> src1_addr=0 reads 0x00000000.
REQ-033 Disabled write: write_enable=0, dest_addr=7, dest_data=0xFFFFFFFF -> x7 keeps prior value 0x00000000.
REQ-034 Dual port: x1=0x00000011, x31=0xA5A5A5A5; src1_addr=1, src2_addr=31 -> 0x00000011 / 0xA5A5A5A5 in the same cycle.
REQ-035 Bypass: x3=0x1, write 0x2 to x3 with src1_addr=3 in the same cycle -> 0x2 pre-edge with REGFILE_BYPASS_EN, 0x1 pre-edge without; 0x2 after the edge in both builds.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants for the register file: default geometry and the hardwired zero index.
package reg_file_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;
  localparam int unsigned NUM_REGS       = 2 ** DEFAULT_ADDR_W;
  localparam int unsigned ZERO_REG       = 0;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: address mux, register-0 force to zero and, when
// REGFILE_BYPASS_EN is defined, same-cycle forwarding of the in-flight write.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] src_addr,
  output logic [DATA_W-1:0] src_data
`ifdef REGFILE_BYPASS_EN
  ,
  input  logic              rst_n,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [DATA_W-1:0] dest_data
`endif
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  // Select the addressed register; register 0 always reads zero.
  always_comb begin
    src_data = '0;
    if (src_addr != ZeroAddr) begin
      src_data = regs[src_addr];
    end
`ifdef REGFILE_BYPASS_EN
    // Forward the pending write, never for x0 and never while held in reset.
    if (rst_n && write_enable && (dest_addr != ZeroAddr) && (dest_addr == src_addr)) begin
      src_data = dest_data;
    end
`endif
  end

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with x0 hardwired to zero.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [DATA_W-1:0] dest_data,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic [ADDR_W-1:0] src2_addr,
  output logic [DATA_W-1:0] src1_data,
  output logic [DATA_W-1:0] src2_data
);

  localparam int unsigned       NRegs    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [NRegs];

  // Storage: async clear, write on rising edge; writes to x0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (write_enable && (dest_addr != ZeroAddr)) begin
      regs_q[dest_addr] <= dest_data;
    end
  end

  reg_file_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_port1 (
    .regs         (regs_q),
    .src_addr     (src1_addr),
    .src_data     (src1_data)
`ifdef REGFILE_BYPASS_EN
    ,
    .rst_n        (rst_n),
    .write_enable (write_enable),
    .dest_addr    (dest_addr),
    .dest_data    (dest_data)
`endif
  );

  reg_file_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_port2 (
    .regs         (regs_q),
    .src_addr     (src2_addr),
    .src_data     (src2_data)
`ifdef REGFILE_BYPASS_EN
    ,
    .rst_n        (rst_n),
    .write_enable (write_enable),
    .dest_addr    (dest_addr),
    .dest_data    (dest_data)
`endif
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file: vector table plus hand-written reset and bypass sequences.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  dest_addr;
  logic [31:0] dest_data;
  logic        write_enable;
  logic [4:0]  src1_addr;
  logic [4:0]  src2_addr;
  logic [31:0] src1_data;
  logic [31:0] src2_data;

  int checks = 0;
  int errors = 0;

  reg_file #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dest_addr    (dest_addr),
    .dest_data    (dest_data),
    .write_enable (write_enable),
    .src1_addr    (src1_addr),
    .src2_addr    (src2_addr),
    .src1_data    (src1_data),
    .src2_data    (src2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Each vector's expectations are read before its own write edge.
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0, 5'd0,  32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd1,  32'h00000011, 5'd5, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd1, 5'd5,  32'h00000011, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 5'd0,  32'h12345678, 5'd1, 5'd31, 32'h00000011, 32'hA5A5A5A5};
    vecs[4] = '{1'b0, 5'd7,  32'hFFFFFFFF, 5'd0, 5'd31, 32'h0,        32'hA5A5A5A5};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd7, 5'd0,  32'h0,        32'h0};
    vecs[6] = '{1'b1, 5'd3,  32'h00000001, 5'd5, 5'd1,  32'hDEADBEEF, 32'h00000011};
    vecs[7] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd3, 5'd31, 32'h00000001, 32'hA5A5A5A5};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd5, 5'd3,  32'hCAFEF00D, 32'h00000001};

    rst_n = 1'b0;
    write_enable = 1'b0;
    dest_addr = '0;
    dest_data = '0;
    src1_addr = 5'd5;
    src2_addr = 5'd31;
    #2;
    check("reset_state_p1", src1_data, 32'h0);
    check("reset_state_p2", src2_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      write_enable = vecs[i].we;
      dest_addr    = vecs[i].waddr;
      dest_data    = vecs[i].wdata;
      src1_addr    = vecs[i].s1;
      src2_addr    = vecs[i].s2;
      #1;
      check($sformatf("vec%0d_p1", i), src1_data, vecs[i].exp1);
      check($sformatf("vec%0d_p2", i), src2_data, vecs[i].exp2);
    end

    // Bypass: x3 holds 1, write 2 while reading it in the same cycle.
    @(negedge clk);
    write_enable = 1'b1;
    dest_addr = 5'd3;
    dest_data = 32'h2;
    src1_addr = 5'd3;
    src2_addr = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_pre_p1", src1_data, 32'h2);
    check("bypass_pre_p2", src2_data, 32'h2);
`else
    check("bypass_pre_p1", src1_data, 32'h1);
    check("bypass_pre_p2", src2_data, 32'h1);
`endif
    @(negedge clk);
    write_enable = 1'b0;
    #1;
    check("bypass_post_p1", src1_data, 32'h2);
    check("bypass_post_p2", src2_data, 32'h2);

    // Forwarding never applies to x0.
    write_enable = 1'b1;
    dest_addr = 5'd0;
    dest_data = 32'h12345678;
    src1_addr = 5'd0;
    #1;
    check("x0_no_fwd", src1_data, 32'h0);
    @(negedge clk);
    write_enable = 1'b0;
    #1;
    check("x0_after_write", src1_data, 32'h0);

    // Fill every register with nonzero data.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      write_enable = 1'b1;
      dest_addr = 5'(i);
      dest_data = 32'h1000_0000 | 32'(i);
    end
    @(negedge clk);
    write_enable = 1'b0;
    src1_addr = 5'd17;
    src2_addr = 5'd31;
    #1;
    check("fill_x17", src1_data, 32'h1000_0011);
    check("fill_x31", src2_data, 32'h1000_001F);

    // Mid-cycle async reset: outputs must drop with no clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_immediate_p1", src1_data, 32'h0);
    check("rst_immediate_p2", src2_data, 32'h0);
    for (int i = 0; i < 32; i++) begin
      src1_addr = 5'(i);
      src2_addr = 5'(31 - i);
      #1;
      check($sformatf("rst_addr%0d_p1", i), src1_data, 32'h0);
      check($sformatf("rst_addr%0d_p2", 31 - i), src2_data, 32'h0);
    end

    // Writes during reset are ignored, and are not forwarded.
    @(negedge clk);
    write_enable = 1'b1;
    dest_addr = 5'd9;
    dest_data = 32'h0000_0099;
    src1_addr = 5'd9;
    #1;
    check("rst_no_fwd", src1_data, 32'h0);
    @(negedge clk);
    write_enable = 1'b0;
    #1;
    check("rst_write_ignored", src1_data, 32'h0);

    // Release reset; the first edge afterwards accepts a write.
    @(negedge clk);
    rst_n = 1'b1;
    write_enable = 1'b1;
    dest_addr = 5'd9;
    dest_data = 32'h0000_0099;
    @(negedge clk);
    write_enable = 1'b0;
    src1_addr = 5'd9;
    src2_addr = 5'd17;
    #1;
    check("resume_x9", src1_data, 32'h0000_0099);
    check("cleared_x17", src2_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
